// File: rtl/addr_ctrl_pkg.sv
// addr_ctrl_pkg: shared state encoding and requester ids for the address-register arbiter.
package addr_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ACCESS, RESP} state_e;
  localparam logic REQ_F = 1'b0;
  localparam logic REQ_D = 1'b1;
endpackage

// File: rtl/arb_timeout_cnt.sv
// arb_timeout_cnt: 8-bit access-wait counter with clear/enable and terminal count at TIMEOUT.
module arb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc_o = cnt_q == 8'(TIMEOUT);
endmodule

// File: rtl/addr_reg_arbiter.sv
// addr_reg_arbiter: shares the address register between fetch (F) and data (D) requesters.
// Define ROUND_ROBIN_EN to alternate tie wins; otherwise F always beats D.
module addr_reg_arbiter
  import addr_ctrl_pkg::*;
#(
  parameter int unsigned word_size = 8,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 f_req,
  input  logic [word_size-1:0] f_addr,
  output logic                 f_ack,
  input  logic                 d_req,
  input  logic [word_size-1:0] d_addr,
  output logic                 d_ack,
  output logic                 err,
  output logic [word_size-1:0] ar_data_in,
  output logic                 ar_load,
  output logic                 mem_en,
  input  logic                 mem_rdy,
  output logic                 busy
);
  state_e state_q, state_d;
  logic [word_size-1:0] addr_q, addr_d;
  logic gnt_q, gnt_d, err_q, err_d, win, tie, grant, tc;
`ifdef ROUND_ROBIN_EN
  logic last_q, last_d;
  assign tie    = ~last_q;
  assign last_d = (state_q == RESP) ? gnt_q : last_q;
  // Starts as "D granted last" so the first tie after reset goes to F.
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_q <= REQ_D;
    else last_q <= last_d;
`else
  assign tie = REQ_F;
`endif
  assign win   = f_req ? (d_req ? tie : REQ_F) : REQ_D;
  assign grant = (state_q == IDLE) && (f_req || d_req);
  // The counter also runs in LOAD so it equals the number of ACCESS cycles including the current one.
  arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr_i(state_q == RESP),
    .en_i ((state_q == LOAD) || (state_q == ACCESS)),
    .tc_o (tc)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      gnt_q   <= REQ_F;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = grant ? LOAD : IDLE;
      LOAD:    state_d = ACCESS;
      ACCESS:  state_d = (mem_rdy || tc) ? RESP : ACCESS;
      default: state_d = IDLE;
    endcase
    gnt_d  = grant ? win : gnt_q;
    addr_d = grant ? (win == REQ_D ? d_addr : f_addr) : addr_q;
    err_d  = (state_q == ACCESS) ? ~mem_rdy : err_q;
  end
  always_comb begin
    ar_load    = state_q == LOAD;
    mem_en     = state_q == ACCESS;
    busy       = state_q != IDLE;
    f_ack      = (state_q == RESP) && (gnt_q == REQ_F);
    d_ack      = (state_q == RESP) && (gnt_q == REQ_D);
    err        = (state_q == RESP) && err_q;
    ar_data_in = addr_q;
  end
endmodule

// File: tb/tb_addr_reg_arbiter.sv
// tb_addr_reg_arbiter: transaction-level model compared every cycle, plus directed literal checks.
module tb_addr_reg_arbiter;
  localparam int TO = 15;
`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, f_req = 1'b0, d_req = 1'b0, mem_rdy = 1'b0;
  logic [7:0] f_addr = '0, d_addr = '0, ar_data_in;
  logic f_ack, d_ack, err, ar_load, mem_en, busy;
  logic e_busy, e_load, e_en, e_fack, e_dack, e_err;
  logic [7:0] e_data;
  int errors = 0, checks = 0, fack_cnt = 0, dack_cnt = 0;
  always #5 clk = ~clk;
  addr_reg_arbiter #(.word_size(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
    .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .err(err),
    .ar_data_in(ar_data_in), .ar_load(ar_load), .mem_en(mem_en),
    .mem_rdy(mem_rdy), .busy(busy)
  );
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [13:0] outs();
    return {busy, ar_load, mem_en, f_ack, d_ack, err, ar_data_in};
  endfunction
  // Model: one thread walks each transaction (grant, load, wait, respond) in whole cycles.
  initial begin : model
    bit gd, ab, rdy, pri_f;
    int w;
    pri_f = 1'b1;
    e_data = '0;
    forever begin
      {e_busy, e_load, e_en, e_fack, e_dack, e_err} = '0;
      @(posedge clk);
      if (!rst) begin e_data = '0; pri_f = 1'b1; continue; end
      if (!f_req && !d_req) continue;
      gd = d_req && (!f_req || (RR && !pri_f));
      e_data = gd ? d_addr : f_addr;
      {e_busy, e_load} = 2'b11;
      @(posedge clk);
      ab = !rst;
      {e_load, e_en} = 2'b01;
      w = 0;
      rdy = 1'b0;
      while (!ab && !rdy && w < TO) begin
        @(posedge clk);
        ab = !rst;
        rdy = mem_rdy;
        w++;
      end
      if (ab) begin e_data = '0; pri_f = 1'b1; continue; end
      {e_en, e_fack, e_dack, e_err} = {1'b0, !gd, gd, !rdy};
      pri_f = gd;
      @(posedge clk);
      if (!rst) begin e_data = '0; pri_f = 1'b1; end
    end
  end
  always @(negedge clk) begin
    if (f_ack) fack_cnt++;
    if (d_ack) dack_cnt++;
    if (rst) chk("cycle", 32'(outs()), 32'({e_busy, e_load, e_en, e_fack, e_dack, e_err, e_data}));
  end
  task automatic nx(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int fa;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", 32'(outs()), 32'h0);
    nx(2); rst = 1'b1;
    nx(1); f_req = 1'b1; f_addr = 8'h3C;
    nx(1); @(negedge clk); chk("t2_load", 32'({ar_load, ar_data_in}), 32'h13C);
    nx(1); @(negedge clk); chk("t2_access", 32'({mem_en, busy}), 32'h3);
    nx(2); mem_rdy = 1'b1;
    nx(1); mem_rdy = 1'b0; f_req = 1'b0;
    @(negedge clk); chk("t2_ack", 32'({f_ack, d_ack, err}), 32'h4);
    chk("t2_no_dack", 32'(dack_cnt), 32'h0);
    nx(1); @(negedge clk); chk("t2_idle", 32'(outs()), 32'h3C);
    nx(1); f_req = 1'b1; d_req = 1'b1; f_addr = 8'h10; d_addr = 8'h20; mem_rdy = 1'b1;
    nx(1); @(negedge clk); chk("t3_load_f", 32'({ar_load, ar_data_in}), 32'h110);
    nx(2); f_req = 1'b0; @(negedge clk); chk("t3_fack", 32'({f_ack, d_ack}), 32'h2);
    nx(1); @(negedge clk); chk("t3_gap", 32'(busy), 32'h0);
    nx(1); @(negedge clk); chk("t3_load_d", 32'({ar_load, ar_data_in}), 32'h120);
    nx(2); d_req = 1'b0; @(negedge clk); chk("t3_dack", 32'({f_ack, d_ack}), 32'h1);
    nx(1); f_req = 1'b1; d_req = 1'b1; f_addr = 8'hA1; d_addr = 8'hD2;
    for (int g = 0; g < 4; g++) begin
      nx(g == 0 ? 3 : 4);
      @(negedge clk);
      chk($sformatf("t4_order%0d", g), 32'({f_ack, d_ack}), (RR && g % 2 == 1) ? 32'h1 : 32'h2);
    end
    f_req = 1'b0; d_req = 1'b0; mem_rdy = 1'b0;
    nx(1); d_req = 1'b1; d_addr = 8'h5A;
    nx(2); @(negedge clk); chk("t5_enter", 32'({mem_en, ar_data_in}), 32'h15A);
    nx(14); @(negedge clk); chk("t5_wait", 32'({mem_en, d_ack}), 32'h2);
    nx(1); d_req = 1'b0; @(negedge clk); chk("t5_timeout", 32'({d_ack, err, f_ack}), 32'h6);
    nx(1); d_req = 1'b1;
    nx(16); mem_rdy = 1'b1;
    nx(1); mem_rdy = 1'b0; d_req = 1'b0;
    @(negedge clk); chk("t5_rdy_at_limit", 32'({d_ack, err}), 32'h2);
    nx(1); mem_rdy = 1'b1; @(negedge clk); chk("t6_idle0", 32'({busy, f_ack, d_ack, err}), 32'h0);
    nx(1); @(negedge clk); chk("t6_idle1", 32'({busy, f_ack, d_ack, err}), 32'h0);
    nx(1); f_req = 1'b1; f_addr = 8'h77; mem_rdy = 1'b0;
    nx(1); mem_rdy = 1'b1; @(negedge clk); chk("t6_load", 32'({ar_load, ar_data_in}), 32'h177);
    nx(1); mem_rdy = 1'b0; @(negedge clk); chk("t6_access", 32'({mem_en, f_ack}), 32'h2);
    nx(1); mem_rdy = 1'b1; @(negedge clk); chk("t6_still", 32'({mem_en, f_ack}), 32'h2);
    nx(1); mem_rdy = 1'b0; f_req = 1'b0; @(negedge clk); chk("t6_ack", 32'({f_ack, err}), 32'h2);
    nx(1); f_req = 1'b1; f_addr = 8'hE7;
    nx(3); fa = fack_cnt; rst = 1'b0;
    @(negedge clk); chk("t1_reset_mid", 32'(outs()), 32'h0);
    nx(1); rst = 1'b1; f_req = 1'b0;
    nx(20);
    chk("t1_no_ack", 32'(fack_cnt - fa), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
